// File: rtl/pipe_mem_port_arbiter.sv
// Arbitrates the single unified memory port between the Fetch and Memory stages.
// One request/ack access at a time, with a bounded wait and a fairness limit on back-to-back M grants.
module pipe_mem_port_arbiter #(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int INSTR_W   = 80,
   parameter int TIMEOUT   = 16,
   parameter int MAX_M_RUN = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               f_req,
   input  logic [ADDR_W-1:0]  f_addr,
   input  logic               m_req,
   input  logic               m_we,
   input  logic [ADDR_W-1:0]  m_addr,
   input  logic [DATA_W-1:0]  m_wdata,
   output logic               f_valid,
   output logic [INSTR_W-1:0] f_data,
   output logic               f_err,
   output logic               m_valid,
   output logic [DATA_W-1:0]  m_rdata,
   output logic               m_err,
   output logic               f_stall_req,
   output logic               m_stall_req,
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic               mem_ack,
   input  logic               mem_err,
   input  logic [INSTR_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam int RUN_W = $clog2(MAX_M_RUN + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY_F,
      S_BUSY_M,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] tmo_cnt;
   logic [RUN_W-1:0] run_cnt;
   logic             grant_m;
   logic             grant_f;
   logic             busy;
   logic             tmo_hit;
   logic             acc_end;
   logic             f_starved;

   assign f_stall_req = f_req & ~f_valid;
   assign m_stall_req = m_req & ~m_valid;

   assign busy      = (state == S_BUSY_F) || (state == S_BUSY_M);
   assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));
   assign acc_end   = busy & (mem_ack | tmo_hit);
   // F has waited out MAX_M_RUN consecutive M grants and must win this one.
   assign f_starved = f_req && (run_cnt == RUN_W'(MAX_M_RUN));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_m   = 1'b0;
      grant_f   = 1'b0;
      case (state)
         S_IDLE: begin
            if (m_req && !f_starved) begin
               grant_m   = 1'b1;
               state_nxt = S_BUSY_M;
            end else if (f_req) begin
               grant_f   = 1'b1;
               state_nxt = S_BUSY_F;
            end
         end
         S_BUSY_F, S_BUSY_M: begin
            if (acc_end) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_valid   <= 1'b0;
         f_data    <= '0;
         f_err     <= 1'b0;
         m_valid   <= 1'b0;
         m_rdata   <= '0;
         m_err     <= 1'b0;
         tmo_cnt   <= '0;
         run_cnt   <= '0;
      end else begin
         f_valid <= 1'b0;
         m_valid <= 1'b0;

         if (grant_m) begin
            mem_req   <= 1'b1;
            mem_we    <= m_we;
            mem_addr  <= m_addr;
            mem_wdata <= m_wdata;
            if (!f_req) begin
               run_cnt <= '0;
            end else if (run_cnt != RUN_W'(MAX_M_RUN)) begin
               run_cnt <= run_cnt + RUN_W'(1);
            end
         end else if (grant_f) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= f_addr;
            mem_wdata <= '0;
            run_cnt   <= '0;
         end

         // An ack on the final allowed cycle still delivers its data.
         if (acc_end) begin
            mem_req <= 1'b0;
            tmo_cnt <= '0;
            if (state == S_BUSY_F) begin
               f_valid <= 1'b1;
               f_err   <= mem_ack ? mem_err : 1'b1;
               f_data  <= mem_ack ? mem_rdata : '0;
            end else begin
               m_valid <= 1'b1;
               m_err   <= mem_ack ? mem_err : 1'b1;
               m_rdata <= (mem_ack && !mem_we) ? mem_rdata[DATA_W-1:0] : '0;
            end
         end else if (busy) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_mem_port_arbiter.sv
// Bench for pipe_mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter.
module tb_pipe_mem_port_arbiter;

   localparam int ADDR_W    = 64;
   localparam int DATA_W    = 64;
   localparam int INSTR_W   = 80;
   localparam int TIMEOUT   = 16;
   localparam int MAX_M_RUN = 4;

   logic               clk;
   logic               rst;
   logic               f_req;
   logic [ADDR_W-1:0]  f_addr;
   logic               m_req;
   logic               m_we;
   logic [ADDR_W-1:0]  m_addr;
   logic [DATA_W-1:0]  m_wdata;
   logic               f_valid;
   logic [INSTR_W-1:0] f_data;
   logic               f_err;
   logic               m_valid;
   logic [DATA_W-1:0]  m_rdata;
   logic               m_err;
   logic               f_stall_req;
   logic               m_stall_req;
   logic               mem_req;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic               mem_ack;
   logic               mem_err;
   logic [INSTR_W-1:0] mem_rdata;

   int n_checks;
   int n_pass;

   pipe_mem_port_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .INSTR_W  (INSTR_W),
      .TIMEOUT  (TIMEOUT),
      .MAX_M_RUN(MAX_M_RUN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .f_req      (f_req),
      .f_addr     (f_addr),
      .m_req      (m_req),
      .m_we       (m_we),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .f_valid    (f_valid),
      .f_data     (f_data),
      .f_err      (f_err),
      .m_valid    (m_valid),
      .m_rdata    (m_rdata),
      .m_err      (m_err),
      .f_stall_req(f_stall_req),
      .m_stall_req(m_stall_req),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_err    (mem_err),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got %0h exp 0", mem_req); else n_pass++;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %0h exp 0", mem_we); else n_pass++;
      n_checks++; if (mem_addr !== '0) $display("FAIL rst_mem_addr got %0h exp 0", mem_addr); else n_pass++;
      n_checks++; if (mem_wdata !== '0) $display("FAIL rst_mem_wdata got %0h exp 0", mem_wdata); else n_pass++;
      n_checks++; if ({f_valid, m_valid, f_err, m_err} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {f_valid, m_valid, f_err, m_err}); else n_pass++;
      n_checks++; if (f_data !== '0) $display("FAIL rst_f_data got %0h exp 0", f_data); else n_pass++;
      n_checks++; if (m_rdata !== '0) $display("FAIL rst_m_rdata got %0h exp 0", m_rdata); else n_pass++;
      rst = 1'b0;
      step();
      n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_idle_mem_req got %0h exp 0", mem_req); else n_pass++;
   endtask

   task automatic test_single_fetch();
      f_req  = 1'b1;
      f_addr = 64'h1000;
      step();
      n_checks++; if (mem_req !== 1'b1) $display("FAIL fetch_mem_req got %0h exp 1", mem_req); else n_pass++;
      n_checks++; if (mem_addr !== 64'h1000) $display("FAIL fetch_mem_addr got %0h exp 1000", mem_addr); else n_pass++;
      n_checks++; if (mem_we !== 1'b0) $display("FAIL fetch_mem_we got %0h exp 0", mem_we); else n_pass++;
      n_checks++; if (f_valid !== 1'b0) $display("FAIL fetch_early_valid got %0h exp 0", f_valid); else n_pass++;
      n_checks++; if (f_stall_req !== 1'b1) $display("FAIL fetch_stall got %0h exp 1", f_stall_req); else n_pass++;
      mem_ack   = 1'b1;
      mem_err   = 1'b0;
      mem_rdata = 80'h30F20A00000000000000;
      step();
      mem_ack = 1'b0;
      n_checks++; if (f_valid !== 1'b1) $display("FAIL fetch_valid_cycle3 got %0h exp 1", f_valid); else n_pass++;
      n_checks++; if (f_data !== 80'h30F20A00000000000000) $display("FAIL fetch_data got %0h exp 30f20a00000000000000", f_data); else n_pass++;
      n_checks++; if (f_err !== 1'b0) $display("FAIL fetch_err got %0h exp 0", f_err); else n_pass++;
      n_checks++; if (mem_req !== 1'b0) $display("FAIL fetch_done_mem_req got %0h exp 0", mem_req); else n_pass++;
      n_checks++; if (f_stall_req !== 1'b0) $display("FAIL fetch_stall_release got %0h exp 0", f_stall_req); else n_pass++;
      f_req = 1'b0;
      step();
      n_checks++; if (f_valid !== 1'b0) $display("FAIL fetch_valid_pulse got %0h exp 0", f_valid); else n_pass++;
   endtask

   task automatic test_contention();
      f_req  = 1'b1;
      f_addr = 64'h2000;
      m_req  = 1'b1;
      m_we   = 1'b0;
      m_addr = 64'h100;
      #1;
      n_checks++; if ({f_stall_req, m_stall_req} !== 2'b11) $display("FAIL cont_stalls got %b exp 11", {f_stall_req, m_stall_req}); else n_pass++;
      step();
      n_checks++; if (mem_addr !== 64'h100) $display("FAIL cont_m_first got %0h exp 100", mem_addr); else n_pass++;
      mem_ack   = 1'b1;
      mem_rdata = 80'hAAAA1122334455667788;
      step();
      mem_ack = 1'b0;
      n_checks++; if (m_valid !== 1'b1) $display("FAIL cont_m_valid got %0h exp 1", m_valid); else n_pass++;
      n_checks++; if (m_rdata !== 64'h1122334455667788) $display("FAIL cont_m_rdata got %0h exp 1122334455667788", m_rdata); else n_pass++;
      n_checks++; if (f_valid !== 1'b0) $display("FAIL cont_f_not_valid got %0h exp 0", f_valid); else n_pass++;
      n_checks++; if (f_stall_req !== 1'b1) $display("FAIL cont_f_stall_a got %0h exp 1", f_stall_req); else n_pass++;
      m_req = 1'b0;
      step();
      n_checks++; if (f_stall_req !== 1'b1) $display("FAIL cont_f_stall_b got %0h exp 1", f_stall_req); else n_pass++;
      step();
      n_checks++; if ({mem_req, mem_addr} !== {1'b1, 64'h2000}) $display("FAIL cont_f_grant got req=%0h addr=%0h exp req=1 addr=2000", mem_req, mem_addr); else n_pass++;
      mem_ack   = 1'b1;
      mem_rdata = 80'h0123456789ABCDEF0011;
      step();
      mem_ack = 1'b0;
      n_checks++; if ({f_valid, f_data} !== {1'b1, 80'h0123456789ABCDEF0011}) $display("FAIL cont_f_result got v=%0h d=%0h exp v=1 d=0123456789abcdef0011", f_valid, f_data); else n_pass++;
      f_req = 1'b0;
      step();
   endtask

   task automatic test_fairness();
      int   grants[6];
      int   exp_seq[6];
      int   ng;
      logic prev_req;
      exp_seq = '{2, 2, 2, 2, 1, 2};
      ng       = 0;
      prev_req = 1'b0;
      f_req    = 1'b1;
      f_addr   = 64'h3000;
      m_req    = 1'b1;
      m_we     = 1'b0;
      m_addr   = 64'h400;
      for (int c = 0; c < 60 && ng < 6; c++) begin
         step();
         if (mem_req && !prev_req) begin
            grants[ng] = (mem_addr == 64'h3000) ? 1 : 2;
            ng++;
         end
         prev_req  = mem_req;
         mem_ack   = mem_req;
         mem_rdata = {16'($urandom), $urandom, $urandom};
         if (m_valid) m_addr = m_addr + 64'd8;
         if (f_valid) f_req = 1'b0;
      end
      n_checks++; if (ng != 6) $display("FAIL fair_grant_count got %0d exp 6", ng); else n_pass++;
      for (int i = 0; i < ng; i++) begin
         n_checks++; if (grants[i] != exp_seq[i]) $display("FAIL fair_grant_%0d got %0d exp %0d (1=F 2=M)", i, grants[i], exp_seq[i]); else n_pass++;
      end
      for (int c = 0; c < 10; c++) begin
         step();
         mem_ack = mem_req;
         if (m_valid) m_req = 1'b0;
      end
      f_req   = 1'b0;
      m_req   = 1'b0;
      mem_ack = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      int   hi;
      logic got;
      hi        = 0;
      got       = 1'b0;
      m_req     = 1'b1;
      m_we      = 1'b0;
      m_addr    = 64'h500;
      mem_ack   = 1'b0;
      mem_rdata = '1;
      for (int c = 0; c < 40 && !got; c++) begin
         step();
         if (mem_req) hi++;
         if (m_valid) begin
            got = 1'b1;
            n_checks++; if (m_err !== 1'b1) $display("FAIL tmo_err got %0h exp 1", m_err); else n_pass++;
            n_checks++; if (m_rdata !== '0) $display("FAIL tmo_rdata got %0h exp 0", m_rdata); else n_pass++;
         end
      end
      n_checks++; if (!got) $display("FAIL tmo_valid_seen got 0 exp 1"); else n_pass++;
      n_checks++; if (hi != TIMEOUT) $display("FAIL tmo_busy_cycles got %0d exp %0d", hi, TIMEOUT); else n_pass++;
      m_req   = 1'b0;
      mem_ack = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         n_checks++; if ({mem_req, m_valid, f_valid} !== 3'b000) $display("FAIL tmo_late_ack_%0d got %b exp 000", c, {mem_req, m_valid, f_valid}); else n_pass++;
      end
      mem_ack = 1'b0;
      // ack arriving on the last allowed BUSY cycle must win
      hi     = 0;
      got    = 1'b0;
      m_req  = 1'b1;
      m_addr = 64'h600;
      for (int c = 0; c < 40 && !got; c++) begin
         step();
         if (mem_req) hi++;
         mem_ack   = (hi == TIMEOUT) && mem_req;
         mem_rdata = 80'h0000CAFEF00D12345678;
         if (m_valid) begin
            got = 1'b1;
            n_checks++; if ({m_err, m_rdata} !== {1'b0, 64'hCAFEF00D12345678}) $display("FAIL tmo_edge_ack got err=%0h d=%0h exp err=0 d=cafef00d12345678", m_err, m_rdata); else n_pass++;
         end
      end
      n_checks++; if (!got) $display("FAIL tmo_edge_valid_seen got 0 exp 1"); else n_pass++;
      m_req   = 1'b0;
      mem_ack = 1'b0;
      step();
   endtask

   task automatic test_write_err();
      m_req   = 1'b1;
      m_we    = 1'b1;
      m_addr  = 64'h200;
      m_wdata = 64'hDEAD;
      step();
      n_checks++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL wr_req_we got %b exp 11", {mem_req, mem_we}); else n_pass++;
      n_checks++; if ({mem_addr, mem_wdata} !== {64'h200, 64'hDEAD}) $display("FAIL wr_addr_data got %0h/%0h exp 200/dead", mem_addr, mem_wdata); else n_pass++;
      step();
      n_checks++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL wr_busy2_we got %b exp 11", {mem_req, mem_we}); else n_pass++;
      mem_ack   = 1'b1;
      mem_err   = 1'b1;
      mem_rdata = 80'h123456789ABCDEF01234;
      step();
      mem_ack = 1'b0;
      mem_err = 1'b0;
      n_checks++; if ({m_valid, m_err} !== 2'b11) $display("FAIL wr_valid_err got %b exp 11", {m_valid, m_err}); else n_pass++;
      n_checks++; if (m_rdata !== '0) $display("FAIL wr_rdata got %0h exp 0", m_rdata); else n_pass++;
      m_req = 1'b0;
      m_we  = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      f_req  = 1'b1;
      f_addr = 64'h7000;
      step();
      step();
      n_checks++; if (mem_req !== 1'b1) $display("FAIL rmid_busy got %0h exp 1", mem_req); else n_pass++;
      rst = 1'b1;
      step();
      n_checks++; if (mem_req !== 1'b0) $display("FAIL rmid_mem_req got %0h exp 0", mem_req); else n_pass++;
      n_checks++; if ({mem_addr, mem_wdata, mem_we} !== '0) $display("FAIL rmid_mem_bus got %0h/%0h/%0h exp 0", mem_addr, mem_wdata, mem_we); else n_pass++;
      n_checks++; if ({f_valid, m_valid, f_err, m_err, f_data, m_rdata} !== '0) $display("FAIL rmid_results got nonzero exp all 0"); else n_pass++;
      rst   = 1'b0;
      f_req = 1'b0;
      step();
      n_checks++; if ({mem_req, f_valid} !== 2'b00) $display("FAIL rmid_idle got %b exp 00", {mem_req, f_valid}); else n_pass++;
   endtask

   task automatic test_random();
      int                 owner;
      int                 done_owner;
      int                 elapsed;
      int                 delay;
      int                 run;
      int                 r;
      logic [ADDR_W-1:0]  a_addr;
      logic               a_we;
      logic [DATA_W-1:0]  a_wdata;
      logic               exp_err;
      logic [INSTR_W-1:0] exp_fd;
      logic [DATA_W-1:0]  exp_md;
      int                 errs_before;
      errs_before = n_checks - n_pass;
      owner = 0; done_owner = 0; elapsed = 0; delay = 0; run = 0;
      a_addr = '0; a_we = 1'b0; a_wdata = '0; exp_err = 1'b0; exp_fd = '0; exp_md = '0;
      f_req = 1'b0; m_req = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         step();
         // advance the model over the edge just taken, using the inputs held before it
         if (done_owner != 0) begin
            done_owner = 0;
         end else if (owner == 0) begin
            if (m_req && !(f_req && run == MAX_M_RUN)) begin
               owner = 2; a_addr = m_addr; a_we = m_we; a_wdata = m_wdata;
               run = f_req ? ((run < MAX_M_RUN) ? run + 1 : run) : 0;
            end else if (f_req) begin
               owner = 1; a_addr = f_addr; a_we = 1'b0; a_wdata = '0;
               run = 0;
            end
            elapsed = 0;
            r = $urandom_range(0, 9);
            delay = (r == 0) ? 1000 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3);
         end else begin
            elapsed++;
            if (mem_ack || elapsed == TIMEOUT) begin
               done_owner = owner;
               exp_err    = mem_ack ? mem_err : 1'b1;
               exp_fd     = mem_ack ? mem_rdata : '0;
               exp_md     = (mem_ack && !a_we) ? mem_rdata[DATA_W-1:0] : '0;
               owner      = 0;
            end
         end
         n_checks++; if (mem_req !== (owner != 0)) $display("FAIL rnd_mem_req cyc %0d got %0h exp %0h", cyc, mem_req, owner != 0); else n_pass++;
         n_checks++; if ({f_valid, m_valid} !== {done_owner == 1, done_owner == 2}) $display("FAIL rnd_valids cyc %0d got %b exp %b", cyc, {f_valid, m_valid}, {done_owner == 1, done_owner == 2}); else n_pass++;
         if (owner != 0) begin
            n_checks++; if ({mem_addr, mem_we, mem_wdata} !== {a_addr, a_we, a_wdata}) $display("FAIL rnd_bus cyc %0d got %0h/%0h/%0h exp %0h/%0h/%0h", cyc, mem_addr, mem_we, mem_wdata, a_addr, a_we, a_wdata); else n_pass++;
         end
         if (done_owner == 1) begin
            n_checks++; if ({f_err, f_data} !== {exp_err, exp_fd}) $display("FAIL rnd_f_result cyc %0d got %0h/%0h exp %0h/%0h", cyc, f_err, f_data, exp_err, exp_fd); else n_pass++;
            f_req = 1'b0;
         end
         if (done_owner == 2) begin
            n_checks++; if ({m_err, m_rdata} !== {exp_err, exp_md}) $display("FAIL rnd_m_result cyc %0d got %0h/%0h exp %0h/%0h", cyc, m_err, m_rdata, exp_err, exp_md); else n_pass++;
            m_req = 1'b0;
         end
         if (!f_req && $urandom_range(0, 2) == 0) begin
            f_req  = 1'b1;
            f_addr = {$urandom, $urandom};
         end
         if (!m_req && $urandom_range(0, 2) == 0) begin
            m_req   = 1'b1;
            m_we    = 1'($urandom_range(0, 1));
            m_addr  = {$urandom, $urandom};
            m_wdata = {$urandom, $urandom};
         end
         mem_ack   = (owner != 0) ? (elapsed == delay) : ($urandom_range(0, 3) == 0);
         mem_err   = ($urandom_range(0, 3) == 0);
         mem_rdata = {16'($urandom), $urandom, $urandom};
         #1;
         n_checks++; if ({f_stall_req, m_stall_req} !== {f_req && done_owner != 1, m_req && done_owner != 2}) $display("FAIL rnd_stalls cyc %0d got %b", cyc, {f_stall_req, m_stall_req}); else n_pass++;
         if ((n_checks - n_pass) - errs_before > 20) begin
            $display("FAIL rnd_abort too many random mismatches at cyc %0d", cyc);
            n_checks++;
            break;
         end
      end
      f_req = 1'b0; m_req = 1'b0; mem_ack = 1'b0;
      for (int c = 0; c < TIMEOUT + 4; c++) step();
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b0;
      f_req     = 1'b0;
      f_addr    = '0;
      m_req     = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      mem_ack   = 1'b0;
      mem_err   = 1'b0;
      mem_rdata = '0;
      #2;
      test_reset();
      test_single_fetch();
      test_contention();
      test_fairness();
      test_timeout();
      test_write_err();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
